// File: rtl/ofifo_psum_accumulator.sv
// ofifo_psum_accumulator
//   Drains psum vectors from the OFIFO, accumulates them over all kernel positions (kij)
//   for each output pixel (nij) in an internal buffer, then streams the final sums out
//   over a valid/ready port.
//
//   Ports
//     clk, reset_n           clock (rising edge), asynchronous active-low reset
//     start                  one-cycle pulse, begins a pass; ignored unless idle
//     num_nij, num_kij       pass geometry, sampled on start
//     ofifo_valid/_rd/_out   OFIFO read side; read data arrives the cycle after ofifo_rd
//     out_valid/_ready       final psum vector handshake
//     out_data, out_idx      final psum vector and its nij index
//     busy, done             pass in progress / one-cycle completion pulse
module ofifo_psum_accumulator #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int max_nij = 64,
    parameter int max_kij = 9,
    parameter bit relu_en = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [$clog2(max_nij):0]     num_nij,
    input  logic [$clog2(max_kij):0]     num_kij,
    input  logic                         ofifo_valid,
    output logic                         ofifo_rd,
    input  logic [psum_bw*col-1:0]       ofifo_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [psum_bw*col-1:0]       out_data,
    output logic [$clog2(max_nij)-1:0]   out_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int NIJ_W = $clog2(max_nij) + 1;
    localparam int KIJ_W = $clog2(max_kij) + 1;
    localparam int IDX_W = $clog2(max_nij);
    localparam int TOT_W = NIJ_W + KIJ_W;
    localparam int DW    = psum_bw * col;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [NIJ_W-1:0]   num_nij_q, num_nij_d;
    logic [TOT_W-1:0]   total_q, total_d;        // words in this pass
    logic [TOT_W-1:0]   issued_q, issued_d;      // read strobes issued
    logic [TOT_W-1:0]   captured_q, captured_d;  // words folded into the buffer
    logic [NIJ_W-1:0]   iss_nij_q, iss_nij_d;    // nij of the next word to read
    logic [KIJ_W-1:0]   iss_kij_q, iss_kij_d;    // kij of the next word to read
    logic               pend_q, pend_d;          // ofifo_out carries a word this cycle
    logic [IDX_W-1:0]   pend_nij_q, pend_nij_d;
    logic               pend_first_q, pend_first_d;
    logic [NIJ_W-1:0]   drain_idx_q, drain_idx_d;

    logic [DW-1:0]      buf_q [max_nij];
    logic [DW-1:0]      acc_base;
    logic [DW-1:0]      acc_sum;
    logic [DW-1:0]      drain_word;
    logic [DW-1:0]      drain_out;
    logic [psum_bw-1:0] lane;

    // NOTE: state registers use non-blocking assignments so every register samples the
    // pre-edge value of every other, independent of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            num_nij_q    <= '0;
            total_q      <= '0;
            issued_q     <= '0;
            captured_q   <= '0;
            iss_nij_q    <= '0;
            iss_kij_q    <= '0;
            pend_q       <= 1'b0;
            pend_nij_q   <= '0;
            pend_first_q <= 1'b0;
            drain_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            num_nij_q    <= num_nij_d;
            total_q      <= total_d;
            issued_q     <= issued_d;
            captured_q   <= captured_d;
            iss_nij_q    <= iss_nij_d;
            iss_kij_q    <= iss_kij_d;
            pend_q       <= pend_d;
            pend_nij_q   <= pend_nij_d;
            pend_first_q <= pend_first_d;
            drain_idx_q  <= drain_idx_d;
        end
    end

    // NOTE: the accumulation buffer has no reset; every entry is written at kij==0 before
    // it is ever read, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (pend_q) begin
            buf_q[pend_nij_q] <= acc_sum;
        end
    end

    // Lane-wise add with natural psum_bw wrap. The buffer is read combinationally, so a
    // word captured in the previous cycle is already visible here: back-to-back words to
    // the same nij (num_nij==1) chain correctly without an explicit bypass.
    always_comb begin
        acc_base = pend_first_q ? '0 : buf_q[pend_nij_q];
        acc_sum  = '0;
        for (int c = 0; c < col; c++) begin
            acc_sum[c*psum_bw +: psum_bw] = acc_base[c*psum_bw +: psum_bw]
                                          + ofifo_out[c*psum_bw +: psum_bw];
        end
    end

    always_comb begin
        drain_word = buf_q[drain_idx_q[IDX_W-1:0]];
        drain_out  = '0;
        lane       = '0;
        for (int c = 0; c < col; c++) begin
            lane = drain_word[c*psum_bw +: psum_bw];
            if (relu_en && lane[psum_bw-1]) begin
                lane = '0;
            end
            drain_out[c*psum_bw +: psum_bw] = lane;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        num_nij_d    = num_nij_q;
        total_d      = total_q;
        issued_d     = issued_q;
        captured_d   = captured_q;
        iss_nij_d    = iss_nij_q;
        iss_kij_d    = iss_kij_q;
        pend_d       = 1'b0;
        pend_nij_d   = pend_nij_q;
        pend_first_d = pend_first_q;
        drain_idx_d  = drain_idx_q;
        ofifo_rd     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_idx      = '0;
        busy         = (state_q != S_IDLE);
        done         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_nij_d   = num_nij;
                    total_d     = TOT_W'(num_nij) * TOT_W'(num_kij);
                    issued_d    = '0;
                    captured_d  = '0;
                    iss_nij_d   = '0;
                    iss_kij_d   = '0;
                    drain_idx_d = '0;
                    state_d     = (num_nij == '0 || num_kij == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                ofifo_rd = ofifo_valid && (issued_q < total_q);
                if (ofifo_rd) begin
                    issued_d     = issued_q + TOT_W'(1);
                    pend_d       = 1'b1;
                    pend_nij_d   = iss_nij_q[IDX_W-1:0];
                    pend_first_d = (iss_kij_q == '0);
                    // Word order is kij-major, nij-minor.
                    if (iss_nij_q == num_nij_q - NIJ_W'(1)) begin
                        iss_nij_d = '0;
                        iss_kij_d = iss_kij_q + KIJ_W'(1);
                    end else begin
                        iss_nij_d = iss_nij_q + NIJ_W'(1);
                    end
                end
                if (pend_q) begin
                    captured_d = captured_q + TOT_W'(1);
                    if (captured_q == total_q - TOT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = drain_out;
                out_idx   = drain_idx_q[IDX_W-1:0];
                if (out_ready) begin
                    if (drain_idx_q == num_nij_q - NIJ_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        drain_idx_d = drain_idx_q + NIJ_W'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ofifo_psum_accumulator.sv
module tb_ofifo_psum_accumulator;

    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int DW  = COL * PBW;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [6:0]     num_nij = '0;
    logic [4:0]     num_kij = '0;
    logic           ofifo_valid = 1'b0;
    logic [DW-1:0]  ofifo_out = '0;
    logic           out_ready = 1'b0;

    logic           ofifo_rd, out_valid, busy, done;
    logic [DW-1:0]  out_data;
    logic [5:0]     out_idx;
    logic           ofifo_rd_r, out_valid_r, busy_r, done_r;
    logic [DW-1:0]  out_data_r;
    logic [5:0]     out_idx_r;

    ofifo_psum_accumulator #(.relu_en(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_nij(num_nij), .num_kij(num_kij),
        .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .ofifo_out(ofifo_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    // Same stimulus, ReLU enabled on the output.
    ofifo_psum_accumulator #(.relu_en(1'b1)) dut_r (
        .clk(clk), .reset_n(reset_n), .start(start), .num_nij(num_nij), .num_kij(num_kij),
        .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd_r), .ofifo_out(ofifo_out),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .out_idx(out_idx_r),
        .busy(busy_r), .done(done_r)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // OFIFO model: words are returned one cycle after the read strobe.
    logic [DW-1:0] words [$];
    int  ptr = 0;
    int  rd_count = 0;
    int  ov_count = 0;
    int  done_count = 0;
    bit  valid_level = 1'b0;
    bit  valid_toggle = 1'b0;
    bit  rd_pending;

    always begin
        @(negedge clk);
        rd_pending = ofifo_rd;
        if (ofifo_rd)  rd_count++;
        if (out_valid) ov_count++;
        if (done)      done_count++;
        @(posedge clk);
        #1;
        if (rd_pending) begin
            if (ptr < words.size()) ofifo_out = words[ptr];
            ptr++;
        end
        ofifo_valid = valid_toggle ? ~ofifo_valid : valid_level;
    end

    logic [DW-1:0] res_data  [64];
    logic [DW-1:0] res_rdata [64];
    int            res_idx   [64];

    function automatic logic [DW-1:0] mkword(input int base, input int step);
        logic [DW-1:0] w;
        for (int c = 0; c < COL; c++) w[c*PBW +: PBW] = 16'(base + step * c);
        return w;
    endfunction

    task automatic clear_counts();
        rd_count = 0;
        ov_count = 0;
        done_count = 0;
        ptr = 0;
    endtask

    task automatic start_pass(input int nij, input int kij);
        @(negedge clk);
        num_nij = 7'(nij);
        num_kij = 5'(kij);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Accept n vectors; after stall_after handshakes hold out_ready low for stall_len
    // valid cycles and require the output to stay frozen meanwhile.
    task automatic collect(input string name, input int n, input int stall_after, input int stall_len);
        int count = 0;
        int stalled = 0;
        int cyc = 0;
        logic [DW-1:0] hold_data = '0;
        logic [5:0]    hold_idx = '0;
        while (count < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (count == stall_after && stalled < stall_len) begin
                out_ready = 1'b0;
                if (out_valid) begin
                    if (stalled == 0) begin
                        hold_data = out_data;
                        hold_idx = out_idx;
                    end else begin
                        n_total++;
                        if ({out_idx, out_data} !== {hold_idx, hold_data})
                            $display("FAIL %s stall_stable: got idx %0d data %h expected idx %0d data %h",
                                     name, out_idx, out_data, hold_idx, hold_data);
                        else n_pass++;
                    end
                    stalled++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                res_idx[count] = int'(out_idx);
                res_data[count] = out_data;
                res_rdata[count] = out_data_r;
                count++;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_total++;
        if (count != n) $display("FAIL %s drain_timeout: got %0d vectors expected %0d", name, count, n);
        else n_pass++;
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_total++;
        if (done !== 1'b1) $display("FAIL %s done_timeout: got done %b expected 1", name, done);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({busy, done} !== 2'b00) $display("FAIL %s after_done: got busy/done %b expected 00", name, {busy, done});
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        valid_level = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({ofifo_rd, out_valid, busy, done} !== 4'b0000)
            $display("FAIL reset_ctrl: got rd/ov/busy/done %b expected 0000", {ofifo_rd, out_valid, busy, done});
        else n_pass++;
        n_total++;
        if ({out_idx, out_data} !== '0)
            $display("FAIL reset_data: got idx %0d data %h expected 0", out_idx, out_data);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    // num_nij=4, num_kij=1: outputs equal the input words.
    task automatic test_single_kij();
        clear_counts();
        words.delete();
        for (int n = 0; n < 4; n++) words.push_back(mkword(10 * n, 1));
        valid_level = 1'b1;
        start_pass(4, 1);
        collect("single_kij", 4, -1, 0);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (res_idx[i] != i || res_data[i] !== mkword(10 * i, 1))
                $display("FAIL single_kij_out%0d: got idx %0d data %h expected idx %0d data %h",
                         i, res_idx[i], res_data[i], i, mkword(10 * i, 1));
            else n_pass++;
        end
        wait_done("single_kij");
        n_total++;
        if (done_count != 1 || rd_count != 4)
            $display("FAIL single_kij_counts: got done %0d rd %0d expected done 1 rd 4", done_count, rd_count);
        else n_pass++;
        valid_level = 1'b0;
    endtask

    // num_nij=4, num_kij=9, every lane +1 -> 9; exactly 36 reads.
    task automatic test_full_kij();
        clear_counts();
        words.delete();
        for (int w = 0; w < 36; w++) words.push_back(mkword(1, 0));
        valid_level = 1'b1;
        start_pass(4, 9);
        collect("full_kij", 4, -1, 0);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (res_idx[i] != i || res_data[i] !== {8{16'd9}})
                $display("FAIL full_kij_out%0d: got idx %0d data %h expected idx %0d data %h",
                         i, res_idx[i], res_data[i], i, {8{16'd9}});
            else n_pass++;
        end
        wait_done("full_kij");
        n_total++;
        if (rd_count != 36) $display("FAIL full_kij_rd_count: got %0d expected 36", rd_count);
        else n_pass++;
        valid_level = 1'b0;
    endtask

    // num_nij=1 back-to-back words: 0x7FFF+1+2 wraps to 0x8002; ReLU gives 0.
    task automatic test_wrap_relu();
        clear_counts();
        words.delete();
        words.push_back({8{16'h7FFF}});
        words.push_back({8{16'h0001}});
        words.push_back({8{16'h0002}});
        valid_level = 1'b1;
        start_pass(1, 3);
        collect("wrap", 1, -1, 0);
        n_total++;
        if (res_idx[0] != 0 || res_data[0] !== {8{16'h8002}})
            $display("FAIL wrap_sum: got idx %0d data %h expected idx 0 data %h", res_idx[0], res_data[0], {8{16'h8002}});
        else n_pass++;
        n_total++;
        if (res_rdata[0] !== '0)
            $display("FAIL wrap_relu: got %h expected 0", res_rdata[0]);
        else n_pass++;
        wait_done("wrap");
        valid_level = 1'b0;
    endtask

    // num_nij=3, num_kij=2 with gappy OFIFO and a 3-cycle output stall.
    // word w lane c = 100*w + c; nij n sum lane c = 200*n + 300 + 2*c.
    task automatic test_stall_gaps();
        clear_counts();
        words.delete();
        for (int w = 0; w < 6; w++) words.push_back(mkword(100 * w, 1));
        valid_toggle = 1'b1;
        start_pass(3, 2);
        collect("stall", 3, 1, 3);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (res_idx[i] != i || res_data[i] !== mkword(200 * i + 300, 2))
                $display("FAIL stall_out%0d: got idx %0d data %h expected idx %0d data %h",
                         i, res_idx[i], res_data[i], i, mkword(200 * i + 300, 2));
            else n_pass++;
        end
        wait_done("stall");
        n_total++;
        if (rd_count != 6) $display("FAIL stall_rd_count: got %0d expected 6", rd_count);
        else n_pass++;
        valid_toggle = 1'b0;
        valid_level = 1'b0;
    endtask

    // Reset mid-ACCUM, then a fresh pass must only show the new words.
    task automatic test_reset_mid_pass();
        clear_counts();
        words.delete();
        for (int w = 0; w < 8; w++) words.push_back(mkword(7000, 0));
        valid_level = 1'b1;
        start_pass(4, 2);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_total++;
        if ({ofifo_rd, out_valid, busy} !== 3'b000)
            $display("FAIL midreset_ctrl: got rd/ov/busy %b expected 000", {ofifo_rd, out_valid, busy});
        else n_pass++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_counts();
        words.delete();
        for (int n = 0; n < 2; n++) words.push_back(mkword(16'h1000 + 16 * n, 1));
        start_pass(2, 1);
        collect("midreset", 2, -1, 0);
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (res_idx[i] != i || res_data[i] !== mkword(16'h1000 + 16 * i, 1))
                $display("FAIL midreset_out%0d: got idx %0d data %h expected idx %0d data %h",
                         i, res_idx[i], res_data[i], i, mkword(16'h1000 + 16 * i, 1));
            else n_pass++;
        end
        wait_done("midreset");
        valid_level = 1'b0;
    endtask

    // num_kij=0: done the cycle after start, no reads, no outputs.
    task automatic test_zero_kij();
        clear_counts();
        valid_level = 1'b1;
        start_pass(4, 0);
        n_total++;
        if (done !== 1'b1) $display("FAIL zero_kij_done: got %b expected 1", done);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_total++;
        if (rd_count != 0 || ov_count != 0 || busy !== 1'b0)
            $display("FAIL zero_kij_quiet: got rd %0d ov %0d busy %b expected 0 0 0", rd_count, ov_count, busy);
        else n_pass++;
        valid_level = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_kij();
        test_full_kij();
        test_wrap_relu();
        test_stall_gaps();
        test_reset_mid_pass();
        test_zero_kij();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
